// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS instruction/data memory arbiter.
package mips_pkg;

  localparam int unsigned MEM_LAT_DEF    = 2;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned BE_W           = 4;
  localparam int unsigned LAT_W          = 3;
  localparam int unsigned STREAK_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  // Command latched from the winning port at grant time.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_cmd_t;

endpackage

// File: rtl/mips_mem_arb_timer.sv
// Memory latency countdown: loads MEM_LAT during ISSUE, flags the last WAIT cycle.
module mips_mem_arb_timer
  import mips_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done_c
);

  logic [LAT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LAT_W'(MEM_LAT);
    end else if (count != '0) begin
      count <= count - LAT_W'(1);
    end
  end

  assign done_c = (count == LAT_W'(1));

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access,
// data-priority with a bounded fetch-starvation streak.
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [BE_W-1:0]   dm_be,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  mem_cmd_t            cmd_q, cmd_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic                if_ready_q, if_ready_d;
  logic                dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                timer_done_c;

  mips_mem_arb_timer #(
    .MEM_LAT(MEM_LAT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state_q == ISSUE),
    .done_c (timer_done_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      cmd_q      <= '0;
      streak_q   <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cmd_q      <= cmd_d;
      streak_q   <= streak_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      if_ready_q <= if_ready_d;
      dm_ready_q <= dm_ready_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cmd_d      = cmd_q;
    streak_d   = streak_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    if_ready_d = 1'b0;
    dm_ready_d = 1'b0;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          // Data wins ties unless the fetch has already been passed over STARVE_MAX times.
          if (dm_req && !(if_req && (streak_q == STREAK_W'(STARVE_MAX)))) begin
            owner_d     = OWN_DM;
            cmd_d.addr  = dm_addr;
            cmd_d.wdata = dm_wdata;
            cmd_d.be    = dm_be;
            mem_we_d    = dm_we;
            if (if_req) begin
              streak_d = streak_q + STREAK_W'(1);
            end
          end else begin
            owner_d     = OWN_IF;
            cmd_d.addr  = if_addr;
            cmd_d.wdata = '0;
            cmd_d.be    = '0;
            streak_d    = '0;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (timer_done_c) begin
          state_d    = DONE;
          rdata_d    = mem_rdata;
          if_ready_d = (owner_q == OWN_IF);
          dm_ready_d = (owner_q == OWN_DM);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_be    = cmd_q.be;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = rdata_q;
  assign dm_rdata  = rdata_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench: two arbiters (MEM_LAT 2 and 1) driven in parallel and
// compared every cycle against a slot-timeline model with its own memory.
module tb_mips_mem_arbiter;

  localparam int STARVE = 4;
  localparam logic [31:0] IF_A = 32'h0000_0300;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_be;

  logic [1:0]  if_ready_o, dm_ready_o, mem_en_o, mem_we_o;
  logic [31:0] if_rdata_o [2];
  logic [31:0] dm_rdata_o [2];
  logic [31:0] mem_addr_o [2];
  logic [31:0] mem_wdata_o [2];
  logic [3:0]  mem_be_o [2];
  logic [31:0] mem_rdata_i [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;

  // Model: one outstanding slot per instance, described by its cycle numbers.
  int          m_issue [2];
  int          m_ready [2];
  int          m_free [2];
  int          m_streak [2];
  logic        m_own_dm [2];
  logic        m_we [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_be [2];
  logic [31:0] m_data [2];
  logic [31:0] ref_mem [2][256];
  logic [31:0] bus_mem [2][256];
  int          due_cyc [2];
  logic [31:0] due_data [2];

  int          en0_q[$];
  logic [31:0] en0_addr_q[$];
  logic        en0_we_q[$];
  int          ifr0_q[$];
  logic [31:0] ifr0_data_q[$];
  int          dmr0_q[$];
  int          en1_q[$];
  int          dmr1_q[$];
  logic        glog0[$];

  always #5 clk = ~clk;

  mips_mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready_o[0]), .if_rdata(if_rdata_o[0]),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_ready(dm_ready_o[0]), .dm_rdata(dm_rdata_o[0]),
    .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
    .mem_wdata(mem_wdata_o[0]), .mem_be(mem_be_o[0]), .mem_rdata(mem_rdata_i[0])
  );

  mips_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready_o[1]), .if_rdata(if_rdata_o[1]),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_ready(dm_ready_o[1]), .dm_rdata(dm_rdata_o[1]),
    .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
    .mem_wdata(mem_wdata_o[1]), .mem_be(mem_be_o[1]), .mem_rdata(mem_rdata_i[1])
  );

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc %0d actual %h required %h", name, k, cyc, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc %0d actual %0d required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic zchk();
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_mem_en", 32'(mem_en_o[k]), 32'd0);
      chk(k, "rst_mem_we", 32'(mem_we_o[k]), 32'd0);
      chk(k, "rst_if_ready", 32'(if_ready_o[k]), 32'd0);
      chk(k, "rst_dm_ready", 32'(dm_ready_o[k]), 32'd0);
      chk(k, "rst_mem_addr", mem_addr_o[k], 32'd0);
      chk(k, "rst_mem_wdata", mem_wdata_o[k], 32'd0);
      chk(k, "rst_mem_be", 32'(mem_be_o[k]), 32'd0);
      chk(k, "rst_if_rdata", if_rdata_o[k], 32'd0);
      chk(k, "rst_dm_rdata", dm_rdata_o[k], 32'd0);
    end
  endtask

  task automatic clear_ev();
    en0_q.delete(); en0_addr_q.delete(); en0_we_q.delete();
    ifr0_q.delete(); ifr0_data_q.delete(); dmr0_q.delete();
    en1_q.delete(); dmr1_q.delete(); glog0.delete();
  endtask

  // One clock cycle: compare outputs, serve memory, drive inputs, advance the model.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dd, input logic [3:0] db,
                      input logic do_rst);
    int   idx;
    logic own_dm;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      logic e_en, e_rdy;
      e_en  = (cyc == m_issue[k]);
      e_rdy = (cyc == m_ready[k]);
      chk(k, "mem_en", 32'(mem_en_o[k]), 32'(e_en));
      chk(k, "mem_we", 32'(mem_we_o[k]), 32'(e_en && m_we[k]));
      chk(k, "if_ready", 32'(if_ready_o[k]), 32'(e_rdy && !m_own_dm[k]));
      chk(k, "dm_ready", 32'(dm_ready_o[k]), 32'(e_rdy && m_own_dm[k]));
      if (e_en) begin
        chk(k, "mem_addr", mem_addr_o[k], m_addr[k]);
        if (m_own_dm[k]) begin
          chk(k, "mem_wdata", mem_wdata_o[k], m_wdata[k]);
          chk(k, "mem_be", 32'(mem_be_o[k]), 32'(m_be[k]));
        end
      end
      if (e_rdy && !m_we[k]) begin
        if (m_own_dm[k]) chk(k, "dm_rdata", dm_rdata_o[k], m_data[k]);
        else             chk(k, "if_rdata", if_rdata_o[k], m_data[k]);
      end
    end
    // Memory answers with the addressed word exactly MEM_LAT cycles after mem_en, noise otherwise.
    for (int k = 0; k < 2; k++) begin
      if (mem_en_o[k]) begin
        idx         = int'(mem_addr_o[k][9:2]);
        due_cyc[k]  = cyc + lat_of(k);
        due_data[k] = bus_mem[k][idx];
        if (mem_we_o[k]) bus_mem[k][idx] = merge(bus_mem[k][idx], mem_wdata_o[k], mem_be_o[k]);
      end
      mem_rdata_i[k] = (due_cyc[k] == cyc) ? due_data[k] : $urandom;
    end
    if (mem_en_o[0]) begin
      en0_q.push_back(cyc); en0_addr_q.push_back(mem_addr_o[0]); en0_we_q.push_back(mem_we_o[0]);
    end
    if (if_ready_o[0]) begin ifr0_q.push_back(cyc); ifr0_data_q.push_back(if_rdata_o[0]); end
    if (dm_ready_o[0]) dmr0_q.push_back(cyc);
    if (mem_en_o[1]) en1_q.push_back(cyc);
    if (dm_ready_o[1]) dmr1_q.push_back(cyc);

    rst = 1'b0;
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd; dm_be = db;
    if (do_rst) begin
      rst = 1'b1;
      #1;
      zchk();
      for (int k = 0; k < 2; k++) begin
        m_issue[k] = -10; m_ready[k] = -10; m_free[k] = cyc + 1;
        m_streak[k] = 0; due_cyc[k] = -10;
      end
    end else if (ir || dr) begin
      for (int k = 0; k < 2; k++) begin
        if (cyc >= m_free[k]) begin
          own_dm = dr && !(ir && m_streak[k] == STARVE);
          m_own_dm[k] = own_dm;
          if (own_dm) begin
            if (ir) m_streak[k]++;
            idx = int'(da[9:2]);
            m_we[k] = dw; m_addr[k] = da; m_wdata[k] = dd; m_be[k] = db;
            m_data[k] = ref_mem[k][idx];
            if (dw) ref_mem[k][idx] = merge(ref_mem[k][idx], dd, db);
          end else begin
            m_streak[k] = 0;
            idx = int'(ia[9:2]);
            m_we[k] = 1'b0; m_addr[k] = ia;
            m_data[k] = ref_mem[k][idx];
          end
          m_issue[k] = cyc + 1;
          m_ready[k] = cyc + lat_of(k) + 2;
          m_free[k]  = cyc + lat_of(k) + 3;
          if (k == 0) glog0.push_back(!own_dm);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
  endtask

  initial begin
    logic [9:0] pat_dut, pat_mod;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_be = '0;
    for (int k = 0; k < 2; k++) begin
      mem_rdata_i[k] = '0;
      m_issue[k] = -10; m_ready[k] = -10; m_free[k] = 0; m_streak[k] = 0;
      m_own_dm[k] = 1'b0; m_we[k] = 1'b0; m_addr[k] = '0; m_wdata[k] = '0;
      m_be[k] = '0; m_data[k] = '0; due_cyc[k] = -10; due_data[k] = '0;
      for (int i = 0; i < 256; i++) begin
        ref_mem[k][i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        bus_mem[k][i] = ref_mem[k][i];
      end
      ref_mem[k][16] = 32'h2010_0005;
      bus_mem[k][16] = 32'h2010_0005;
    end
    repeat (2) @(negedge clk);
    zchk();

    // Fetch only from 0x40.
    do_reset(); clear_ev();
    step(1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    t0 = cyc;
    chki("model_if_ready_lat", m_ready[0] - t0, 4);
    idle(6);
    chki("f_en_count", en0_q.size(), 1);
    chki("f_en_cycle", (en0_q.size() > 0) ? en0_q[0] - t0 : -1, 1);
    chk(0, "f_en_we", (en0_we_q.size() > 0) ? 32'(en0_we_q[0]) : 32'hFFFF_FFFF, 32'd0);
    chk(0, "f_en_addr", (en0_addr_q.size() > 0) ? en0_addr_q[0] : 32'hFFFF_FFFF, 32'h40);
    chki("f_ready_cycle", (ifr0_q.size() > 0) ? ifr0_q[0] - t0 : -1, 4);
    chk(0, "f_rdata", (ifr0_data_q.size() > 0) ? ifr0_data_q[0] : 32'hFFFF_FFFF, 32'h2010_0005);
    chki("f_dm_ready_count", dmr0_q.size(), 0);

    // Simultaneous store and fetch: store first, fetch in the next slot.
    do_reset(); clear_ev();
    step(1'b1, 32'h200, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b0);
    t0 = cyc;
    repeat (5) step(1'b1, 32'h200, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    idle(6);
    chki("s_en0_cycle", (en0_q.size() > 0) ? en0_q[0] - t0 : -1, 1);
    chk(0, "s_en0_we", (en0_we_q.size() > 0) ? 32'(en0_we_q[0]) : 32'hFFFF_FFFF, 32'd1);
    chki("s_dm_ready_cycle", (dmr0_q.size() > 0) ? dmr0_q[0] - t0 : -1, 4);
    chki("s_en1_cycle", (en0_q.size() > 1) ? en0_q[1] - t0 : -1, 6);
    chki("s_if_ready_cycle", (ifr0_q.size() > 0) ? ifr0_q[0] - t0 : -1, 9);

    // Both held: fetch gets every fifth slot.
    do_reset(); clear_ev();
    repeat (50) step(1'b1, IF_A, 1'b1, 1'b0, 32'h180, 32'd0, 4'd0, 1'b0);
    idle(6);
    pat_dut = '0; pat_mod = '0;
    for (int i = 0; i < 10; i++) begin
      if (i < en0_addr_q.size()) pat_dut[i] = (en0_addr_q[i] == IF_A);
      if (i < glog0.size()) pat_mod[i] = glog0[i];
    end
    chki("starve_grants", en0_q.size(), 10);
    chk(0, "starve_pattern", 32'(pat_dut), 32'h210);
    chk(0, "model_starve_pattern", 32'(pat_mod), 32'h210);

    // Reset in WAIT abandons the load; held request is re-arbitrated.
    do_reset(); clear_ev();
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h80, 32'd0, 4'd0, 1'b0);
    t0 = cyc;
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h80, 32'd0, 4'd0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h80, 32'd0, 4'd0, 1'b1);
    clear_ev();
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h80, 32'd0, 4'd0, 1'b0);
    idle(8);
    chki("r_en_cycle", (en0_q.size() > 0) ? en0_q[0] - t0 : -1, 4);
    chki("r_first_ready", (dmr0_q.size() > 0) ? dmr0_q[0] - t0 : -1, 7);
    chki("r_ready_count", dmr0_q.size(), 1);

    // MEM_LAT=1 instance with a load held across three slots.
    do_reset(); clear_ev();
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h44, 32'd0, 4'd0, 1'b0);
    t0 = cyc;
    repeat (11) step(1'b0, 32'd0, 1'b1, 1'b0, 32'h44, 32'd0, 4'd0, 1'b0);
    idle(6);
    chki("l1_en_count", en1_q.size(), 3);
    chki("l1_ready_count", dmr1_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chki("l1_en_cycle", (en1_q.size() > i) ? en1_q[i] - t0 : -1, 1 + 4 * i);
      chki("l1_ready_cycle", (dmr1_q.size() > i) ? dmr1_q[i] - t0 : -1, 3 + 4 * i);
    end

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom, $urandom, 4'($urandom), $urandom_range(0, 299) == 0);
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
